mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- read_a  in  1  instruction-port read request.
- address_a  in  32  instruction-port address.
- resp_a  out  1  instruction-port completion pulse.
- rdata_a  out  32  instruction-port read data.
- read_b  in  1  data-port read request.
- write_b  in  1  data-port write request.
- wmask_b  in  4  data-port byte-enable.
- address_b  in  32  data-port address.
- wdata_b  in  32  data-port write data.
- resp_b  out  1  data-port completion pulse.
- rdata_b  out  32  data-port read data.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_wmask  out  4  memory byte-enable.
- pmem_address  out  32  memory address.
- pmem_wdata  out  32  memory write data.
- pmem_resp  in  1  memory completion, one-cycle pulse.
- pmem_rdata  in  32  memory read data, valid with pmem_resp.

Function
REQ-003 The FSM SHALL have states IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B.
REQ-004 In IDLE, pmem_read, pmem_write, resp_a and resp_b SHALL be 0.
REQ-005 In IDLE, a pending B request (read_b|write_b) SHALL be granted when no A request is pending. B's address, wdata, wmask and write flag are latched, and the FSM goes to SERVE_B.
REQ-006 In IDLE, a pending A request SHALL be granted when no B request is pending. address_a is latched and the FSM goes to SERVE_A.
REQ-007 When both A and B are pending in IDLE, the port not granted last SHALL win. A 1-bit last_grant register updates on every grant.
REQ-008 read_b and write_b both high SHALL be treated as a write. The read is ignored.
REQ-009 In SERVE_x, pmem_* SHALL be driven only from the latched request. Requester inputs changing or dropping mid-service have no effect.
REQ-010 In SERVE_x, the FSM SHALL hold until pmem_resp=1. It then captures pmem_rdata into the rdata_x register and moves to DONE_x.
REQ-011 In DONE_x, resp_x SHALL be 1 for exactly one cycle, then the FSM returns to IDLE. Requests are not sampled in DONE_x.
REQ-012 rdata_a and rdata_b SHALL be registered and hold their last value until overwritten by a completion on the same port. A write completion leaves rdata_b unchanged.
REQ-013 Latency SHALL be: grant at edge t, pmem strobe in cycle t+1, resp_x in the cycle after pmem_resp. Minimum request-to-resp is 3 cycles.
REQ-014 A request still asserted in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-015 pmem_resp received in IDLE or DONE_x SHALL be ignored.
REQ-016 resp_a and resp_b SHALL never be high in the same cycle.
REQ-017 pmem_read and pmem_write SHALL never be high in the same cycle.

Reset
REQ-018 When rst=1 at an edge, the FSM SHALL go to IDLE and last_grant to A, so B wins the first tie. rdata_a, rdata_b and all latched request fields clear to 0.
REQ-019 After reset all outputs SHALL be 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no resp pulse. The memory side is reset by the same rst.

Structure
REQ-021 The state enum arb_state_t SHALL live in the shared package rv32i_types.
REQ-022 The grant/FSM logic SHALL be in mem_arbiter. The request latch SHALL be one sub-module, arb_req_reg, with fields address, wdata, wmask, is_write and is_read, and with load and reset inputs.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Lone A: read_a=1, address_a=0x60, memory returns 0xDEADBEEF after 2 cycles -> pmem_read with pmem_address=0x60, then one resp_a with rdata_a=0xDEADBEEF; resp_b stays 0.
- Lone B write: write_b=1, address_b=0x104, wdata_b=0x12345678, wmask_b=4'b0011 -> pmem_write=1 with those values; one resp_b; rdata_b unchanged.
- Tie after reset: read_a and read_b assert together -> B served first, then A; the next tie grants B again (alternation).
- Mid-service change: address_b changes 0x200->0x300 during SERVE_B -> pmem_address stays 0x200 until pmem_resp.
- Reset mid-service: rst in SERVE_A with pmem_resp not yet seen -> no resp_a; IDLE; all outputs 0 the next cycle.
- Spurious pmem_resp in IDLE -> no state change, no resp pulse.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the latched request layout.
package rv32i_types;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_A,
        SERVE_B,
        DONE_A,
        DONE_B
    } arb_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_write;
        logic        is_read;
    } arb_req_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/arb_req_reg.sv
// Holds the granted request so the memory side never sees requester inputs mid-service.
module arb_req_reg (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    input  logic        i_is_write,
    input  logic        i_is_read,
    output logic [31:0] o_address,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    output logic        o_is_write,
    output logic        o_is_read
);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_address  <= '0;
            o_wdata    <= '0;
            o_wmask    <= '0;
            o_is_write <= 1'b0;
            o_is_read  <= 1'b0;
        end else if (i_load) begin
            o_address  <= i_address;
            o_wdata    <= i_wdata;
            o_wmask    <= i_wmask;
            o_is_write <= i_is_write;
            o_is_read  <= i_is_read;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction A / data B) arbiter onto a single memory port; ties alternate
// between the ports, one transaction in flight at a time.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic [31:0] address_a,
    output logic        resp_a,
    output logic [31:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [3:0]  wmask_b,
    input  logic [31:0] address_b,
    input  logic [31:0] wdata_b,
    output logic        resp_b,
    output logic [31:0] rdata_b,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [3:0]  pmem_wmask,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    arb_state_t r_state, w_next;
    logic       r_last_grant;
    logic       w_grant_a, w_grant_b, w_b_pend, w_serve;
    arb_req_t   w_ld, w_cur;

    assign w_b_pend = read_b | write_b;

    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            IDLE: begin
                // B wins a tie only when A was granted last
                if (w_b_pend && (!read_a || r_last_grant == GRANT_A)) begin
                    w_grant_b = 1'b1;
                    w_next    = SERVE_B;
                end else if (read_a) begin
                    w_grant_a = 1'b1;
                    w_next    = SERVE_A;
                end
            end
            SERVE_A: if (pmem_resp) w_next = DONE_A;
            SERVE_B: if (pmem_resp) w_next = DONE_B;
            DONE_A:  w_next = IDLE;
            DONE_B:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ld = '{address: address_a, wdata: '0, wmask: '0, is_write: 1'b0, is_read: 1'b1};
        if (w_grant_b) begin
            // simultaneous read+write is served as a write
            w_ld = '{address: address_b, wdata: wdata_b, wmask: wmask_b,
                     is_write: write_b, is_read: ~write_b};
        end
    end

    arb_req_reg u_req (
        .clk        (clk),
        .i_rst      (rst),
        .i_load     (w_grant_a | w_grant_b),
        .i_address  (w_ld.address),
        .i_wdata    (w_ld.wdata),
        .i_wmask    (w_ld.wmask),
        .i_is_write (w_ld.is_write),
        .i_is_read  (w_ld.is_read),
        .o_address  (w_cur.address),
        .o_wdata    (w_cur.wdata),
        .o_wmask    (w_cur.wmask),
        .o_is_write (w_cur.is_write),
        .o_is_read  (w_cur.is_read)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_A;
            rdata_a      <= '0;
            rdata_b      <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_a) r_last_grant <= GRANT_A;
            if (w_grant_b) r_last_grant <= GRANT_B;
            if (r_state == SERVE_A && pmem_resp) rdata_a <= pmem_rdata;
            if (r_state == SERVE_B && pmem_resp && w_cur.is_read) rdata_b <= pmem_rdata;
        end
    end

    assign w_serve      = (r_state == SERVE_A) || (r_state == SERVE_B);
    assign pmem_read    = w_serve & w_cur.is_read;
    assign pmem_write   = w_serve & w_cur.is_write;
    assign pmem_address = w_cur.address;
    assign pmem_wdata   = w_cur.wdata;
    assign pmem_wmask   = w_cur.wmask;
    assign resp_a       = (r_state == DONE_A);
    assign resp_b       = (r_state == DONE_B);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_a = 1'b0, read_b = 1'b0, write_b = 1'b0, pmem_resp = 1'b0;
    logic [31:0] address_a = '0, address_b = '0, wdata_b = '0, pmem_rdata = '0;
    logic [3:0]  wmask_b = '0;
    logic        resp_a, resp_b, pmem_read, pmem_write;
    logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
    logic [3:0]  pmem_wmask;

    int n_checks = 0;
    int n_err    = 0;

    // model state: outstanding request contents, last winner, expected read data
    logic [31:0] ea_addr, eb_addr, eb_wdata;
    logic [3:0]  eb_wmask;
    logic        eb_wr;
    logic        exp_last_b;
    logic [31:0] exp_rd_a, exp_rd_b;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit pick_b(input bit a, input bit b, input bit last_b);
        if (a && b) return !last_b;
        return b;
    endfunction

    task automatic chk_zero_all(input string tag);
        chk({tag, "_resp"}, 32'({resp_a, resp_b}), 32'd0);
        chk({tag, "_strobe"}, 32'({pmem_read, pmem_write}), 32'd0);
        chk({tag, "_rdata_a"}, rdata_a, 32'd0);
        chk({tag, "_rdata_b"}, rdata_b, 32'd0);
        chk({tag, "_addr"}, pmem_address, 32'd0);
        chk({tag, "_wdata"}, pmem_wdata, 32'd0);
        chk({tag, "_wmask"}, 32'(pmem_wmask), 32'd0);
    endtask

    task automatic model_reset;
        exp_last_b = 1'b0;
        exp_rd_a   = '0;
        exp_rd_b   = '0;
    endtask

    task automatic drive_a(input logic [31:0] addr);
        ea_addr   = addr;
        address_a = addr;
        read_a    = 1'b1;
    endtask

    // op: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic drive_b(input int op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm);
        eb_addr   = addr;  eb_wdata = wd;  eb_wmask = wm;
        eb_wr     = (op != 0);
        address_b = addr;  wdata_b  = wd;  wmask_b  = wm;
        read_b    = (op != 1);
        write_b   = (op != 0);
    endtask

    // Entered at the IDLE cycle with the request(s) already driven; leaves at the
    // IDLE cycle following the completion pulse.
    task automatic run_txn(input bit win_b, input int d, input logic [31:0] data, input bit mutate);
        chk("idle_quiet", 32'({pmem_read, pmem_write, resp_a, resp_b}), 32'd0);
        tick;
        for (int i = 0; i <= d; i++) begin
            if (win_b) begin
                chk("b_addr", pmem_address, eb_addr);
                chk("b_write", 32'(pmem_write), 32'(eb_wr));
                chk("b_read", 32'(pmem_read), 32'(!eb_wr));
                if (eb_wr) begin
                    chk("b_wdata", pmem_wdata, eb_wdata);
                    chk("b_wmask", 32'(pmem_wmask), 32'(eb_wmask));
                end
            end else begin
                chk("a_addr", pmem_address, ea_addr);
                chk("a_strobe", 32'({pmem_read, pmem_write}), 32'b10);
            end
            chk("serve_noresp", 32'({resp_a, resp_b}), 32'd0);
            if (i == 0 && mutate) begin
                if (win_b) address_b = address_b ^ 32'h100;
                else       address_a = address_a ^ 32'h100;
            end
            if (i == d) begin
                pmem_resp  = 1'b1;
                pmem_rdata = data;
            end
            tick;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = $urandom;
        exp_last_b = win_b;
        if (win_b && !eb_wr) exp_rd_b = data;
        if (!win_b)          exp_rd_a = data;
        chk("done_resp", 32'({resp_a, resp_b}), win_b ? 32'b01 : 32'b10);
        chk("done_strobe", 32'({pmem_read, pmem_write}), 32'd0);
        chk("rdata_a", rdata_a, exp_rd_a);
        chk("rdata_b", rdata_b, exp_rd_b);
        if (win_b) begin read_b = 1'b0; write_b = 1'b0; end
        else       read_a = 1'b0;
        tick;
        chk("resp_one_cycle", 32'({resp_a, resp_b}), 32'd0);
    endtask

    initial begin
        bit a_p, b_p, w;
        model_reset();
        tick; tick;
        chk_zero_all("reset");
        rst = 1'b0;

        // lone A read
        drive_a(32'h60);
        run_txn(1'b0, 2, 32'hDEADBEEF, 1'b0);

        // lone B write: rdata_b must stay put
        drive_b(1, 32'h104, 32'h12345678, 4'b0011);
        run_txn(1'b1, 1, 32'hCAFEF00D, 1'b0);

        // tie right after reset: B, then A, then B again
        rst = 1'b1; tick; rst = 1'b0;
        model_reset();
        drive_a(32'h10);
        drive_b(0, 32'h20, 32'h0, 4'h0);
        run_txn(pick_b(1, 1, exp_last_b), 0, 32'h1111_0001, 1'b0);
        run_txn(pick_b(1, 0, exp_last_b), 1, 32'h2222_0002, 1'b0);
        drive_a(32'h30);
        drive_b(0, 32'h40, 32'h0, 4'h0);
        run_txn(pick_b(1, 1, exp_last_b), 0, 32'h3333_0003, 1'b0);
        run_txn(pick_b(1, 0, exp_last_b), 0, 32'h4444_0004, 1'b0);

        // requester address changes 0x200 -> 0x300 mid-service
        drive_b(0, 32'h200, 32'h0, 4'h0);
        run_txn(1'b1, 2, 32'h5555_0005, 1'b1);

        // reset while A is being served
        drive_a(32'h80);
        tick;
        chk("rst_mid_serving", 32'(pmem_read), 32'd1);
        rst = 1'b1; read_a = 1'b0;
        tick;
        rst = 1'b0;
        model_reset();
        chk_zero_all("rst_mid");
        tick;
        chk("rst_mid_late", 32'({resp_a, resp_b, pmem_read, pmem_write}), 32'd0);

        // stray pmem_resp in IDLE
        pmem_resp = 1'b1; pmem_rdata = 32'hBAD0BAD0;
        tick;
        pmem_resp = 1'b0;
        chk("spur_resp", 32'({resp_a, resp_b, pmem_read, pmem_write}), 32'd0);
        chk("spur_rdata_a", rdata_a, exp_rd_a);
        tick;
        chk("spur_resp2", 32'({resp_a, resp_b}), 32'd0);
        drive_a(32'h90);
        run_txn(1'b0, 0, 32'h6666_0006, 1'b0);

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            a_p = 1'($urandom_range(0, 1));
            b_p = 1'($urandom_range(0, 1));
            if (!a_p && !b_p) a_p = 1'b1;
            if (a_p) drive_a($urandom);
            if (b_p) drive_b(int'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom));
            while (a_p || b_p) begin
                w = pick_b(a_p, b_p, exp_last_b);
                run_txn(w, int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
                if (w) b_p = 1'b0;
                else   a_p = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
